// File: rtl/cc_unit.sv
// rtl/cc_unit.sv - LC-3 condition-code unit: registered NZP/BEN with NZP save/restore LIFO (optional CC_BYPASS_EN)
module cc_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic [WIDTH-1:0]                   bus_in,
    input  logic                               ld_cc,
    input  logic                               ld_ben,
    input  logic [2:0]                         ir_nzp,
    input  logic                               push,
    input  logic                               pop,
    output logic [2:0]                         nzp_out,
    output logic                               ben_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_out,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               unf_err
);
    localparam int DW    = $clog2(STACK_DEPTH + 1);
    // Array is sized to the full index range so depth-1 at depth 0 stays in bounds.
    localparam int SLOTS = 1 << DW;

    logic [2:0]    stack [SLOTS];
    logic [2:0]    nzp;
    logic          ben;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;

    logic [2:0]    cls;
    logic [2:0]    top;
    logic [DW-1:0] top_idx;
    logic          full;
    logic          empty;
    logic          swap;
    logic          push_ok;
    logic          pop_ok;
    logic          pop_valid;
    logic [2:0]    nzp_next;
    logic [2:0]    ben_sel;

    // Classify the bus, resolve push/pop legality and the next NZP value.
    always_comb begin
        cls       = 3'b001;
        if (bus_in == '0) begin
            cls = 3'b010;
        end else if (bus_in[WIDTH-1]) begin
            cls = 3'b100;
        end
        full      = (depth == DW'(STACK_DEPTH));
        empty     = (depth == '0);
        top_idx   = depth - DW'(1);
        top       = stack[top_idx];
        swap      = push && pop && !empty;
        push_ok   = (push && !pop && !full) || (push && pop && empty);
        pop_ok    = pop && !push && !empty;
        pop_valid = swap || pop_ok;
        nzp_next  = nzp;
        if (pop_valid) begin
            nzp_next = top;
        end else if (ld_cc) begin
            nzp_next = cls;
        end
`ifdef CC_BYPASS_EN
        ben_sel   = nzp_next;
`else
        ben_sel   = nzp;
`endif
    end

    // Flag, depth and sticky error registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            nzp   <= 3'b010;
            ben   <= 1'b0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            nzp <= nzp_next;
            if (ld_ben) begin
                ben <= |(ir_nzp & ben_sel);
            end
            if (push_ok) begin
                depth <= depth + DW'(1);
            end else if (pop_ok) begin
                depth <= depth - DW'(1);
            end
            if (push && !pop && full) begin
                ovf <= 1'b1;
            end
            if (pop && !push && empty) begin
                unf <= 1'b1;
            end
        end
    end

    // Stack storage; a swap overwrites the top slot, a push fills the next slot.
    always_ff @(posedge Clk) begin
        if (Reset_n) begin
            if (swap) begin
                stack[top_idx] <= nzp;
            end else if (push_ok) begin
                stack[depth] <= nzp;
            end
        end
    end

    assign nzp_out     = nzp;
    assign ben_out     = ben;
    assign depth_out   = depth;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf;
    assign unf_err     = unf;
endmodule

// File: tb/tb_cc_unit.sv
// tb/tb_cc_unit.sv - self-checking bench for cc_unit against a queue-based reference model
module tb_cc_unit;
    localparam int WIDTH = 16;
    localparam int SD    = 4;
    localparam int DW    = $clog2(SD + 1);

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic [WIDTH-1:0] bus_in = '0;
    logic             ld_cc = 1'b0;
    logic             ld_ben = 1'b0;
    logic [2:0]       ir_nzp = 3'b000;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [2:0]       nzp_out;
    logic             ben_out;
    logic [DW-1:0]    depth_out;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    logic [2:0] stk[$];
    logic [2:0] m_nzp;
    logic       m_ben;
    logic       m_ovf;
    logic       m_unf;

`ifdef CC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    cc_unit #(.WIDTH(WIDTH), .STACK_DEPTH(SD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus_in(bus_in), .ld_cc(ld_cc), .ld_ben(ld_ben),
        .ir_nzp(ir_nzp), .push(push), .pop(pop), .nzp_out(nzp_out), .ben_out(ben_out),
        .depth_out(depth_out), .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] v);
        if (v == 0) return 3'b010;
        if (v[WIDTH-1]) return 3'b100;
        return 3'b001;
    endfunction

    // Reference model: the stack is a plain queue, the rules applied case by case.
    always @(posedge Clk) begin
        if (!Reset_n) begin
            m_nzp = 3'b010; m_ben = 0; m_ovf = 0; m_unf = 0;
            stk.delete();
        end else begin
            logic [2:0] old_nzp, new_nzp;
            bit popped;
            old_nzp = m_nzp;
            popped  = 0;
            new_nzp = old_nzp;
            if (push && pop && stk.size() > 0) begin
                new_nzp = stk.pop_back();
                stk.push_back(old_nzp);
                popped = 1;
            end else if (push && (pop || stk.size() < SD)) begin
                stk.push_back(old_nzp);
            end else if (push) begin
                m_ovf = 1;
            end else if (pop && stk.size() > 0) begin
                new_nzp = stk.pop_back();
                popped = 1;
            end else if (pop) begin
                m_unf = 1;
            end
            if (!popped && ld_cc) new_nzp = classify(bus_in);
            if (ld_ben) m_ben = |(ir_nzp & (BYPASS ? new_nzp : old_nzp));
            m_nzp = new_nzp;
        end
    end

    // Compare process: all outputs against the model, every cycle once reset has been seen.
    always @(negedge Clk) begin
        if (checking) begin
            check("nzp", nzp_out, m_nzp);
            check("ben", ben_out, m_ben);
            check("depth", depth_out, stk.size());
            check("full", stack_full, stk.size() == SD);
            check("empty", stack_empty, stk.size() == 0);
            check("ovf", ovf_err, m_ovf);
            check("unf", unf_err, m_unf);
            check("onehot", $countones(nzp_out), 1);
        end
    end

    task automatic cyc(input logic c, input logic [WIDTH-1:0] b, input logic lb,
                       input logic [2:0] ir, input logic pu, input logic po);
        ld_cc = c; bus_in = b; ld_ben = lb; ir_nzp = ir; push = pu; pop = po;
        @(posedge Clk); #1;
        ld_cc = 0; ld_ben = 0; push = 0; pop = 0;
    endtask

    task automatic do_reset();
        Reset_n = 0;
        cyc(0, 0, 0, 0, 0, 0);
        Reset_n = 1;
    endtask

    initial begin
        do_reset();
        checking = 1;
        // 1: reset then idle
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        check("t1_nzp", nzp_out, 3'b010);
        check("t1_ben", ben_out, 0);
        check("t1_depth", depth_out, 0);
        check("t1_empty", stack_empty, 1);
        check("t1_ovf", ovf_err, 0);
        check("t1_unf", unf_err, 0);
        // 2: classification
        cyc(1, 16'h0000, 0, 0, 0, 0); check("t2_zero", nzp_out, 3'b010);
        cyc(1, 16'h8001, 0, 0, 0, 0); check("t2_neg", nzp_out, 3'b100);
        cyc(1, 16'h7FFF, 0, 0, 0, 0); check("t2_pos", nzp_out, 3'b001);
        // 3: BEN
        cyc(0, 0, 1, 3'b001, 0, 0); check("t3_ben_p", ben_out, 1);
        cyc(0, 0, 1, 3'b110, 0, 0); check("t3_ben_nz", ben_out, 0);
        cyc(0, 0, 1, 3'b001, 0, 0); check("t3_ben_p2", ben_out, 1);
        cyc(0, 0, 1, 3'b000, 0, 0); check("t3_ben_none", ben_out, 0);
        cyc(1, 16'h0000, 1, 3'b010, 0, 0);
        check("t3_ben_same", ben_out, BYPASS ? 1 : 0);
        check("t3_nzp_same", nzp_out, 3'b010);
        // 4: fill, overflow, drain, underflow
        do_reset();
        cyc(1, 16'h8000, 0, 0, 0, 0);
        cyc(1, 16'h0000, 0, 0, 1, 0);
        cyc(1, 16'h0001, 0, 0, 1, 0);
        cyc(1, 16'h8000, 0, 0, 1, 0);
        cyc(1, 16'h0000, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("t4_depth", depth_out, 4);
        check("t4_full", stack_full, 1);
        check("t4_ovf", ovf_err, 1);
        cyc(0, 0, 0, 0, 0, 1); check("t4_pop1", nzp_out, 3'b100);
        cyc(0, 0, 0, 0, 0, 1); check("t4_pop2", nzp_out, 3'b001);
        cyc(0, 0, 0, 0, 0, 1); check("t4_pop3", nzp_out, 3'b010);
        cyc(0, 0, 0, 0, 0, 1); check("t4_pop4", nzp_out, 3'b100);
        cyc(0, 0, 0, 0, 0, 1);
        check("t4_unf", unf_err, 1);
        check("t4_hold", nzp_out, 3'b100);
        // 5: swap and push with same-cycle load
        do_reset();
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 16'h8000, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        check("t5_swap_nzp", nzp_out, 3'b010);
        check("t5_swap_depth", depth_out, 1);
        check("t5_swap_err", {ovf_err, unf_err}, 2'b00);
        cyc(0, 0, 0, 0, 0, 1); check("t5_swap_top", nzp_out, 3'b100);
        cyc(1, 16'h0000, 0, 0, 0, 0);
        cyc(1, 16'hFFFF, 0, 0, 1, 0); check("t5_ldpush_nzp", nzp_out, 3'b100);
        cyc(0, 0, 0, 0, 0, 1); check("t5_ldpush_saved", nzp_out, 3'b010);
        // 6: reset mid-sequence
        do_reset();
        repeat (5) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("t6_pre_depth", depth_out, 3);
        check("t6_pre_ovf", ovf_err, 1);
        do_reset();
        check("t6_nzp", nzp_out, 3'b010);
        check("t6_depth", depth_out, 0);
        check("t6_errs", {ovf_err, unf_err, ben_out}, 3'b000);
        cyc(0, 0, 0, 0, 0, 1); check("t6_unf", unf_err, 1);
        // Random traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] b;
            case ($urandom_range(0, 2))
                0: b = '0;
                1: b = WIDTH'($urandom) | (WIDTH'(1) << (WIDTH - 1));
                default: b = WIDTH'($urandom) & ~(WIDTH'(1) << (WIDTH - 1));
            endcase
            Reset_n = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 1), b, $urandom_range(0, 1), 3'($urandom),
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        Reset_n = 1;
        @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
